// File: rtl/cpu_pkg.sv
// Shared CPU constants: register-file op codes, bank geometry and requester ids.
package cpu_pkg;

  localparam int unsigned NREG = 8;
  localparam int unsigned DW   = 16;

  localparam logic [1:0] OpIdle = 2'b00;
  localparam logic [1:0] OpLoad = 2'b01;
  localparam logic [1:0] OpInc  = 2'b11;

  typedef enum logic {
    ReqA = 1'b0,
    ReqB = 1'b1
  } req_id_e;

  function automatic logic op_is_valid(logic [1:0] op);
    return (op == OpLoad) || (op == OpInc);
  endfunction

endpackage

// File: rtl/regsel_decode.sv
// Register index to one-hot write enable, with an out-of-range flag for partial banks.
module regsel_decode #(
  parameter int unsigned NREG = 8
) (
  input  logic [$clog2(NREG)-1:0] dst,
  input  logic                    valid,
  output logic [NREG-1:0]         selection,
  output logic                    out_of_range
);

  localparam int unsigned IdxW = $clog2(NREG);

  // A power-of-two bank cannot be addressed out of range.
  if (NREG == (1 << IdxW)) begin : g_full
    assign out_of_range = 1'b0;
  end else begin : g_part
    assign out_of_range = (32'(dst) >= NREG);
  end

  always_comb begin
    selection = '0;
    for (int i = 0; i < NREG; i++) begin
      if (valid && !out_of_range && (dst == IdxW'(i))) begin
        selection[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing the register-file write path between writeback (A) and load (B).
module reg_write_arbiter #(
  parameter int unsigned NREG = 8,
  parameter int unsigned DW   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_a,
  input  logic [1:0]              op_a,
  input  logic [$clog2(NREG)-1:0] dst_a,
  input  logic [DW-1:0]           data_a,
  output logic                    gnt_a,
  input  logic                    req_b,
  input  logic [1:0]              op_b,
  input  logic [$clog2(NREG)-1:0] dst_b,
  input  logic [DW-1:0]           data_b,
  output logic                    gnt_b,
  output logic [1:0]              sm_op,
  output logic [NREG-1:0]         selection,
  output logic [DW-1:0]           data_bus,
  output logic                    busy,
  output logic                    err
);

  import cpu_pkg::*;

  localparam int unsigned IdxW = $clog2(NREG);

  logic            gnt_a_q, gnt_a_d, gnt_b_q, gnt_b_d;
  logic [1:0]      sm_op_q, sm_op_d;
  logic [NREG-1:0] sel_q, sel_d;
  logic [DW-1:0]   data_q, data_d;
  logic            err_q, err_d;
  req_id_e         last_q, last_d;

  logic            elig_a, elig_b, pick_a, pick_b, pick_any;
  logic [1:0]      win_op;
  logic [IdxW-1:0] win_dst;
  logic [DW-1:0]   win_data;
  logic            win_op_ok, win_ok;
  logic [NREG-1:0] dec_sel;
  logic            dec_oor;

  // A requester granted this cycle sits out the next arbitration so it can drop req.
  assign elig_a   = req_a && !gnt_a_q;
  assign elig_b   = req_b && !gnt_b_q;
  assign pick_a   = elig_a && (!elig_b || (last_q == ReqB));
  assign pick_b   = elig_b && !pick_a;
  assign pick_any = pick_a || pick_b;

  assign win_op    = pick_a ? op_a   : op_b;
  assign win_dst   = pick_a ? dst_a  : dst_b;
  assign win_data  = pick_a ? data_a : data_b;
  assign win_op_ok = op_is_valid(win_op);
  assign win_ok    = win_op_ok && !dec_oor;

  regsel_decode #(
    .NREG(NREG)
  ) u_regsel_decode (
    .dst          (win_dst),
    .valid        (pick_any && win_op_ok),
    .selection    (dec_sel),
    .out_of_range (dec_oor)
  );

  always_comb begin
    gnt_a_d = 1'b0;
    gnt_b_d = 1'b0;
    sm_op_d = OpIdle;
    sel_d   = '0;
    data_d  = data_q;
    err_d   = err_q;
    last_d  = last_q;
    if (pick_any) begin
      gnt_a_d = pick_a;
      gnt_b_d = pick_b;
      last_d  = pick_a ? ReqA : ReqB;
      if (win_ok) begin
        sm_op_d = win_op;
        sel_d   = dec_sel;
        data_d  = (win_op == OpLoad) ? win_data : '0;
      end else begin
        // Malformed request is consumed but never reaches the bank.
        data_d = '0;
        err_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_a_q <= 1'b0;
      gnt_b_q <= 1'b0;
      sm_op_q <= OpIdle;
      sel_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      last_q  <= ReqB;
    end else begin
      gnt_a_q <= gnt_a_d;
      gnt_b_q <= gnt_b_d;
      sm_op_q <= sm_op_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      err_q   <= err_d;
      last_q  <= last_d;
    end
  end

  assign gnt_a     = gnt_a_q;
  assign gnt_b     = gnt_b_q;
  assign sm_op     = sm_op_q;
  assign selection = sel_q;
  assign data_bus  = data_q;
  assign busy      = |sel_q;
  assign err       = err_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed and random bench for reg_write_arbiter against a register-bank reference model.
module tb_reg_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_a, req_b;
  logic [1:0]  op_a, op_b;
  logic [2:0]  dst_a, dst_b;
  logic [15:0] data_a, data_b;
  logic        gnt_a, gnt_b;
  logic [1:0]  sm_op;
  logic [7:0]  selection;
  logic [15:0] data_bus;
  logic        busy, err;

  always #5 clk = ~clk;

  reg_write_arbiter #(
    .NREG(8),
    .DW  (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_a    (req_a),
    .op_a     (op_a),
    .dst_a    (dst_a),
    .data_a   (data_a),
    .gnt_a    (gnt_a),
    .req_b    (req_b),
    .op_b     (op_b),
    .dst_b    (dst_b),
    .data_b   (data_b),
    .gnt_b    (gnt_b),
    .sm_op    (sm_op),
    .selection(selection),
    .data_bus (data_bus),
    .busy     (busy),
    .err      (err)
  );

  // Register bank fed by the DUT's write path.
  logic [15:0] bank [8] = '{default: 16'h0000};
  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (selection[i] && sm_op == 2'b01) bank[i] <= data_bus;
      else if (selection[i] && sm_op == 2'b11) bank[i] <= bank[i] + 16'd1;
    end
  end

  int total = 0;
  int bad   = 0;

  // Reference model state.
  bit          e_ga, e_gb, m_last, m_err;
  logic [1:0]  e_sm;
  logic [7:0]  e_sel;
  logic [15:0] e_bus;
  logic [15:0] mregs [8] = '{default: 16'h0000};
  bit          pend_v;
  logic [1:0]  pend_op;
  int          pend_dst;
  logic [15:0] pend_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    e_ga = 0; e_gb = 0; e_sm = 2'b00; e_sel = 8'h00; e_bus = 16'h0000;
    m_err = 0; m_last = 1; pend_v = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".gnt_a"}, 32'(gnt_a), 32'(e_ga));
    chk({tag, ".gnt_b"}, 32'(gnt_b), 32'(e_gb));
    chk({tag, ".sm_op"}, 32'(sm_op), 32'(e_sm));
    chk({tag, ".sel"}, 32'(selection), 32'(e_sel));
    chk({tag, ".bus"}, 32'(data_bus), 32'(e_bus));
    chk({tag, ".busy"}, 32'(busy), 32'(e_sel != 8'h00));
    chk({tag, ".err"}, 32'(err), 32'(m_err));
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 8; i++) chk($sformatf("%s.reg%0d", tag, i), 32'(bank[i]), 32'(mregs[i]));
  endtask

  task automatic drive(input bit ra, input logic [1:0] oa, input logic [2:0] da,
                       input logic [15:0] xa, input bit rb, input logic [1:0] ob,
                       input logic [2:0] db, input logic [15:0] xb);
    req_a = ra; op_a = oa; dst_a = da; data_a = xa;
    req_b = rb; op_b = ob; dst_b = db; data_b = xb;
  endtask

  // One clock: predict from current inputs, advance, compare.
  task automatic cycle(input string tag);
    int         win;
    logic [1:0] op;
    int         dst;
    logic [15:0] data;
    bit         ea, eb;
    if (pend_v) begin
      if (pend_op == 2'b01) mregs[pend_dst] = pend_data;
      else mregs[pend_dst] = mregs[pend_dst] + 16'd1;
    end
    pend_v = 0;
    ea = req_a && !e_ga;
    eb = req_b && !e_gb;
    if (ea && eb) win = m_last ? 0 : 1;
    else if (ea) win = 0;
    else if (eb) win = 1;
    else win = -1;
    e_ga = (win == 0);
    e_gb = (win == 1);
    e_sm = 2'b00;
    e_sel = 8'h00;
    if (win >= 0) begin
      op   = (win == 1) ? op_b : op_a;
      dst  = (win == 1) ? int'(dst_b) : int'(dst_a);
      data = (win == 1) ? data_b : data_a;
      m_last = (win == 1);
      if ((op == 2'b01 || op == 2'b11) && dst < 8) begin
        e_sm = op;
        e_sel = 8'(1) << dst;
        e_bus = (op == 2'b01) ? data : 16'h0000;
        pend_v = 1; pend_op = op; pend_dst = dst; pend_data = data;
      end else begin
        m_err = 1;
        e_bus = 16'h0000;
      end
    end
    @(posedge clk);
    #1;
    check_all(tag);
    check_regs(tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 2'b00, 3'd0, 16'h0, 0, 2'b00, 3'd0, 16'h0);
    model_reset();
    #2;
    check_all("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle("idle");

    drive(1, 2'b01, 3'd3, 16'hBEEF, 0, 2'b00, 3'd0, 16'h0);
    cycle("loadA");
    chk("loadA.sel_lit", 32'(selection), 32'h08);
    chk("loadA.bus_lit", 32'(data_bus), 32'hBEEF);
    drive(0, 2'b00, 3'd0, 16'h0, 0, 2'b00, 3'd0, 16'h0);
    cycle("loadA_done");
    chk("loadA.reg3_lit", 32'(bank[3]), 32'hBEEF);

    drive(1, 2'b11, 3'd1, 16'h0, 1, 2'b01, 3'd2, 16'h0005);
    for (int i = 0; i < 6; i++) begin
      cycle($sformatf("alt%0d", i));
      chk($sformatf("alt%0d.busy_lit", i), 32'(busy), 32'h1);
    end
    do_reset("rst_async");
    cycle("post_rst");
    chk("post_rst.a_first", 32'(gnt_a), 32'h1);
    cycle("post_rst2");
    drive(0, 2'b00, 3'd0, 16'h0, 0, 2'b00, 3'd0, 16'h0);
    cycle("post_rst_idle");

    drive(1, 2'b01, 3'd5, 16'h1234, 0, 2'b00, 3'd0, 16'h0);
    cycle("holdA1");
    chk("holdA1.lit", 32'(gnt_a), 32'h1);
    cycle("holdA2");
    chk("holdA2.lit", 32'(gnt_a), 32'h0);
    cycle("holdA3");
    chk("holdA3.lit", 32'(gnt_a), 32'h1);
    drive(0, 2'b00, 3'd0, 16'h0, 0, 2'b00, 3'd0, 16'h0);
    cycle("holdA_idle");

    drive(0, 2'b00, 3'd0, 16'h0, 1, 2'b10, 3'd0, 16'hAAAA);
    cycle("badop");
    chk("badop.err_lit", 32'(err), 32'h1);
    chk("badop.sel_lit", 32'(selection), 32'h0);
    drive(0, 2'b00, 3'd0, 16'h0, 0, 2'b00, 3'd0, 16'h0);
    cycle("badop_idle1");
    cycle("badop_idle2");
    chk("badop.sticky", 32'(err), 32'h1);

    drive(0, 2'b00, 3'd0, 16'h0, 1, 2'b01, 3'd7, 16'hFFFF);
    cycle("load7");
    drive(0, 2'b00, 3'd0, 16'h0, 0, 2'b00, 3'd0, 16'h0);
    cycle("load7_idle");
    drive(0, 2'b00, 3'd0, 16'h0, 1, 2'b11, 3'd7, 16'h5A5A);
    cycle("inc7");
    chk("inc7.bus_lit", 32'(data_bus), 32'h0);
    drive(0, 2'b00, 3'd0, 16'h0, 0, 2'b00, 3'd0, 16'h0);
    cycle("inc7_idle");
    chk("inc7.wrap_lit", 32'(bank[7]), 32'h0);

    do_reset("rst_rand");
    for (int i = 0; i < 300; i++) begin
      drive(bit'($urandom_range(0, 1)),
            (i < 150) ? {1'b1, 1'b1} & 2'(($urandom_range(0, 1) << 1) | 1) : 2'($urandom_range(0, 3)),
            3'($urandom_range(0, 7)), 16'($urandom),
            bit'($urandom_range(0, 1)),
            (i < 150) ? 2'(($urandom_range(0, 1) << 1) | 1) : 2'($urandom_range(0, 3)),
            3'($urandom_range(0, 7)), 16'($urandom));
      cycle($sformatf("rand%0d", i));
    end
    drive(0, 2'b00, 3'd0, 16'h0, 0, 2'b00, 3'd0, 16'h0);
    cycle("final_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
